// File: rtl/weight_buf_fill_pkg.sv
// Shared types and constants for the weight buffer fill path.
// Default-configuration constants live here; modules derive their own from parameters.
package weight_buf_fill_pkg;
  localparam int WB_TN      = 16;
  localparam int WB_TM      = 16;
  localparam int WB_K       = 3;
  localparam int KK         = WB_K * WB_K;
  localparam int TILE_WORDS = WB_TN * WB_TM * KK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Counter width that stays legal when a dimension collapses to 1.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/weight_fill_counter.sv
// Cascaded kk -> tm -> tn pop counter with last-pop flag and running tn*K*K base,
// so the bank address needs only an adder.
module weight_fill_counter
  import weight_buf_fill_pkg::*;
#(
  parameter int AW = 12,
  parameter int Tn = 16,
  parameter int Tm = 16,
  parameter int K  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  output logic [cw(K*K)-1:0]     kk,
  output logic [cw(Tm)-1:0]      tm,
  output logic [AW-1:0]          base,
  output logic                   last
);
  localparam int KKL = K * K;
  localparam int KKW = cw(KKL);
  localparam int TMW = cw(Tm);
  localparam int TNW = cw(Tn);

  logic [KKW-1:0] kk_q, kk_d;
  logic [TMW-1:0] tm_q, tm_d;
  logic [TNW-1:0] tn_q, tn_d;
  logic [AW-1:0]  base_q, base_d;

  logic kk_wrap, tm_wrap, tn_wrap;
  assign kk_wrap = (kk_q == KKW'(KKL - 1));
  assign tm_wrap = (tm_q == TMW'(Tm - 1));
  assign tn_wrap = (tn_q == TNW'(Tn - 1));

  always_comb begin
    kk_d   = kk_q;
    tm_d   = tm_q;
    tn_d   = tn_q;
    base_d = base_q;
    if (clr) begin
      kk_d   = '0;
      tm_d   = '0;
      tn_d   = '0;
      base_d = '0;
    end else if (en) begin
      if (!kk_wrap) begin
        kk_d = kk_q + 1'b1;
      end else begin
        kk_d = '0;
        if (!tm_wrap) begin
          tm_d = tm_q + 1'b1;
        end else begin
          tm_d   = '0;
          tn_d   = tn_wrap ? '0 : tn_q + 1'b1;
          base_d = tn_wrap ? '0 : base_q + AW'(KKL);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kk_q   <= '0;
      tm_q   <= '0;
      tn_q   <= '0;
      base_q <= '0;
    end else begin
      kk_q   <= kk_d;
      tm_q   <= tm_d;
      tn_q   <= tn_d;
      base_q <= base_d;
    end
  end

  assign kk   = kk_q;
  assign tm   = tm_q;
  assign base = base_q;
  assign last = kk_wrap && tm_wrap && tn_wrap;
endmodule

// File: rtl/weight_buf_fill.sv
// Pops one Tn x Tm x K x K weight tile from the load FIFO and scatters it into Tm banks.
// Optional WEIGHT_BUF_FILL_CHECKSUM_EN adds fill_csum, the running sum of written words.
module weight_buf_fill
  import weight_buf_fill_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int Tn = WB_TN,
  parameter int Tm = WB_TM,
  parameter int K  = WB_K
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill_start,
  output logic          fill_done,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  input  logic [DW-1:0] fifo_rdata,
  output logic [Tm-1:0] wr_ena,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy
`ifdef WEIGHT_BUF_FILL_CHECKSUM_EN
  , output logic [DW-1:0] fill_csum
`endif
);
  localparam int TMW = cw(Tm);

  state_e            state_q, state_d;
  logic              start_acc;
  logic [cw(K*K)-1:0] kk;
  logic [TMW-1:0]    tm;
  logic [AW-1:0]     base;
  logic              last;

  // Stage 1 holds the pop tag while the FIFO presents its data.
  logic              p1_vld_q, p1_vld_d;
  logic [TMW-1:0]    p1_tm_q, p1_tm_d;
  logic [AW-1:0]     p1_addr_q, p1_addr_d;
  logic [Tm-1:0]     wr_ena_q, wr_ena_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;

  assign start_acc = (state_q == IDLE) && fill_start;
  assign fifo_rd   = (state_q == FILL) && !fifo_empty;

  weight_fill_counter #(.AW(AW), .Tn(Tn), .Tm(Tm), .K(K)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .en   (fifo_rd),
    .kk   (kk),
    .tm   (tm),
    .base (base),
    .last (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (fill_start) state_d = FILL;
      FILL:  if (fifo_rd && last) state_d = FLUSH;
      // Stage 1 empty means the final word is on the write port this cycle.
      FLUSH: if (!p1_vld_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p1_vld_d  = fifo_rd;
    p1_tm_d   = tm;
    p1_addr_d = base + AW'(kk);
    wr_ena_d  = p1_vld_q ? (Tm'(1) << p1_tm_q) : '0;
    wr_addr_d = p1_addr_q;
    wr_data_d = fifo_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      p1_vld_q  <= 1'b0;
      p1_tm_q   <= '0;
      p1_addr_q <= '0;
      wr_ena_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      p1_vld_q  <= p1_vld_d;
      p1_tm_q   <= p1_tm_d;
      p1_addr_q <= p1_addr_d;
      wr_ena_q  <= wr_ena_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef WEIGHT_BUF_FILL_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_acc)      csum_d = '0;
    else if (|wr_ena_q) csum_d = csum_q + wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign fill_csum = csum_q;
`endif

  assign wr_ena    = wr_ena_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign fill_done = (state_q == DONE);
  assign busy      = (state_q != IDLE);
endmodule
